// File: rtl/fifo_thr_pkg.sv
// Shared sizing helpers and parameter legality check for the fifo_thr block.
package fifo_thr_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return ($clog2(depth) > 1) ? $clog2(depth) : 1;
  endfunction

  // Legal configurations: DEPTH >= 2 and AEMPTY_THR < AFULL_THR <= DEPTH.
  function automatic bit cfg_ok(input int depth, input int afull_thr, input int aempty_thr);
    return (depth >= 2) && (aempty_thr < afull_thr) && (afull_thr <= depth);
  endfunction

endpackage

// File: rtl/fifo_thr_ram.sv
// Simple dual-port DEPTH x DWIDTH storage: synchronous write, asynchronous read.
module fifo_thr_ram
  import fifo_thr_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [DWIDTH-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [DWIDTH-1:0]        rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the pointers and count alone define which words are valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_thr.sv
// Synchronous FIFO with thresholds, occupancy count, sticky error flags, flush and FWFT mode.
// Optional FIFO_THR_HWM_EN adds a registered high-water-mark output hwm_o.
module fifo_thr
  import fifo_thr_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int DEPTH      = 32,
  parameter int FWFT       = 1,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [DWIDTH-1:0]        data_i,
  input  logic                     wr,
  output logic                     full_o,
  output logic                     afull_o,
  output logic [DWIDTH-1:0]        data_o,
  input  logic                     rd,
  output logic                     empty_o,
  output logic                     aempty_o,
  output logic [cnt_w(DEPTH)-1:0] count_o,
  output logic                     ovf_o,
  output logic                     udf_o
`ifdef FIFO_THR_HWM_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] hwm_o
`endif
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam bit FWFT_MODE = (FWFT != 0);
  localparam bit CFG_OK = cfg_ok(DEPTH, AFULL_THR, AEMPTY_THR);
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

  if (!CFG_OK) begin : g_cfg_err
    $error("fifo_thr: illegal DEPTH / threshold parameters");
  end

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DWIDTH-1:0] ram_rdata;
  logic              wr_ok, rd_ok, ram_has, bypass, ram_we, ram_re;
  logic [CW-1:0]     count_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // In FWFT mode the output register holds the head, so the RAM only has data beyond one word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    wr_ok     = 1'b0;
    rd_ok     = 1'b0;
    ram_has   = 1'b0;
    bypass    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    count_nxt = '0;
    if (!flush) begin
      rd_ok     = rd & ~empty_o;
      wr_ok     = wr & (~full_o | rd_ok);
      ram_has   = FWFT_MODE ? (count_o > CW'(1)) : (count_o != '0);
      bypass    = FWFT_MODE & wr_ok & (empty_o | (rd_ok & ~ram_has));
      ram_we    = wr_ok & ~bypass;
      ram_re    = rd_ok & ram_has;
      count_nxt = count_o + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  fifo_thr_ram #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr),
    .wdata(data_i),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_o  <= '0;
      full_o   <= 1'b0;
      afull_o  <= (AFULL_THR == 0);
      empty_o  <= 1'b1;
      aempty_o <= 1'b1;
      data_o   <= '0;
      ovf_o    <= 1'b0;
      udf_o    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (ram_we) wr_ptr <= ptr_inc(wr_ptr);
        if (ram_re) rd_ptr <= ptr_inc(rd_ptr);
      end
      if (ram_re)      data_o <= ram_rdata;
      else if (bypass) data_o <= data_i;
      count_o  <= count_nxt;
      full_o   <= (count_nxt == FULL_C);
      afull_o  <= (count_nxt >= AFULL_C);
      empty_o  <= (count_nxt == '0);
      aempty_o <= (count_nxt <= AEMPTY_C);
      ovf_o    <= ~flush & (ovf_o | (wr & ~wr_ok));
      udf_o    <= ~flush & (udf_o | (rd & ~rd_ok));
    end
  end

`ifdef FIFO_THR_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  hwm_o <= '0;
    else if (flush)              hwm_o <= '0;
    else if (count_nxt > hwm_o)  hwm_o <= count_nxt;
  end
`endif

endmodule
